// File: rtl/lot_tracker.sv
// -----------------------------------------------------------------------------
// lot_tracker
//
// Purpose:
//   Counts vehicles in a parking lot from two gate light beams. The outer
//   beam (A) and the inner beam (B) are crossed in the order
//   10 -> 11 -> 01 -> 00 by an entering car and in the order
//   01 -> 11 -> 10 -> 00 by an exiting car ({A,B}, 1 = blocked). A sequence
//   FSM follows the car through the gate. It tolerates a car stopping on
//   any beam pattern and a car reversing one step at a time. It pulses err
//   on impossible transitions.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-high reset
//   A      in   outer beam, synchronized to CLK, 1 = blocked
//   B      in   inner beam, synchronized to CLK, 1 = blocked
//   enter  out  one-cycle pulse per accepted entry
//   exit   out  one-cycle pulse per accepted exit
//   count  out  registered occupancy, 0..CAPACITY
//   full   out  count == CAPACITY
//   empty  out  count == 0
//   err    out  one-cycle pulse on illegal transition or rejected update
// -----------------------------------------------------------------------------
module lot_tracker #(
  parameter int CAPACITY = 25,
  parameter int CW       = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          A,
  input  logic          B,
  output logic          enter,
  output logic          exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          enter_q, enter_d;
  logic          exit_q,  exit_d;
  logic          err_q,   err_d;

  logic [1:0] ab;
  logic       in_req;
  logic       out_req;
  logic       seq_err;

  assign ab = {A, B};

  // Sequence tracking. E* states follow an entering car, X* states an
  // exiting car. In both chains, the previous beam pattern steps back one
  // state. An impossible pattern drops back to IDLE with an error.
  always_comb begin
    state_d = state_q;
    in_req  = 1'b0;
    out_req = 1'b0;
    seq_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (ab)
          2'b10:   state_d = E1;
          2'b01:   state_d = X1;
          2'b11:   seq_err = 1'b1;
          default: state_d = IDLE;
        endcase
      end
      E1: begin
        unique case (ab)
          2'b10:   state_d = E1;
          2'b11:   state_d = E2;
          2'b00:   state_d = IDLE;              // car backed out, not an error
          default: begin state_d = IDLE; seq_err = 1'b1; end
        endcase
      end
      E2: begin
        unique case (ab)
          2'b11:   state_d = E2;
          2'b01:   state_d = E3;
          2'b10:   state_d = E1;
          default: begin state_d = IDLE; seq_err = 1'b1; end
        endcase
      end
      E3: begin
        unique case (ab)
          2'b01:   state_d = E3;
          2'b00:   begin state_d = IDLE; in_req = 1'b1; end
          2'b11:   state_d = E2;
          default: begin state_d = IDLE; seq_err = 1'b1; end
        endcase
      end
      X1: begin
        unique case (ab)
          2'b01:   state_d = X1;
          2'b11:   state_d = X2;
          2'b00:   state_d = IDLE;
          default: begin state_d = IDLE; seq_err = 1'b1; end
        endcase
      end
      X2: begin
        unique case (ab)
          2'b11:   state_d = X2;
          2'b10:   state_d = X3;
          2'b01:   state_d = X1;
          default: begin state_d = IDLE; seq_err = 1'b1; end
        endcase
      end
      X3: begin
        unique case (ab)
          2'b10:   state_d = X3;
          2'b00:   begin state_d = IDLE; out_req = 1'b1; end
          2'b11:   state_d = X2;
          default: begin state_d = IDLE; seq_err = 1'b1; end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Count update. A completed sequence that would push the count outside
  // 0..CAPACITY is reported as an error. The count does not change.
  always_comb begin
    count_d = count_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    err_d   = seq_err;
    if (in_req) begin
      if (count_q == CAP_C) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
        enter_d = 1'b1;
      end
    end else if (out_req) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q - CW'(1);
        exit_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
    end
  end

  assign enter = enter_q;
  assign exit  = exit_q;
  assign err   = err_q;
  assign count = count_q;
  assign full  = (count_q == CAP_C);
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_lot_tracker.sv
// -----------------------------------------------------------------------------
// tb_lot_tracker
//
// Self-checking bench for lot_tracker. The reference model describes each
// gate passage as a walk along a fixed four-step beam path. The entry path
// is 10,11,01,00 and the exit path is 01,11,10,00. The walk tracks the
// current position, so the bench does not need the RTL state names.
// -----------------------------------------------------------------------------
module tb_lot_tracker;

  localparam int CAPACITY = 25;
  localparam int CW       = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          A   = 1'b0;
  logic          B   = 1'b0;
  logic          enter, exit, full, empty, err;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  lot_tracker #(.CAPACITY(CAPACITY), .CW(CW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .A     (A),
    .B     (B),
    .enter (enter),
    .exit  (exit),
    .count (count),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [1:0] path [2][4];
  int  m_dir;   // 0 = no car in gate, 1 = entering, 2 = exiting
  int  m_pos;   // 1..3 = index of the pattern currently held on the path
  int  m_occ;
  bit  m_enter, m_exit, m_err;

  // DUT pulse tallies since the last clear_tallies call
  int  n_enter, n_exit, n_err;

  initial begin
    path[0][0] = 2'b10; path[0][1] = 2'b11; path[0][2] = 2'b01; path[0][3] = 2'b00;
    path[1][0] = 2'b01; path[1][1] = 2'b11; path[1][2] = 2'b10; path[1][3] = 2'b00;
  end

  function automatic void model_reset();
    m_dir = 0; m_pos = 0; m_occ = 0;
    m_enter = 0; m_exit = 0; m_err = 0;
  endfunction

  function automatic void model_step(input logic [1:0] ab);
    int d;
    m_enter = 0; m_exit = 0; m_err = 0;
    if (m_dir == 0) begin
      if (ab == 2'b10)      begin m_dir = 1; m_pos = 1; end
      else if (ab == 2'b01) begin m_dir = 2; m_pos = 1; end
      else if (ab == 2'b11) m_err = 1;
    end else begin
      d = m_dir - 1;
      if (ab == path[d][m_pos-1]) begin
        // car stationary
      end else if (ab == path[d][m_pos]) begin
        if (m_pos == 3) begin
          m_dir = 0;
          if (d == 0) begin
            if (m_occ == CAPACITY) m_err = 1;
            else begin m_occ++; m_enter = 1; end
          end else begin
            if (m_occ == 0) m_err = 1;
            else begin m_occ--; m_exit = 1; end
          end
        end else begin
          m_pos++;
        end
      end else if (m_pos == 1 && ab == 2'b00) begin
        m_dir = 0;                          // backed out of the gate
      end else if (m_pos >= 2 && ab == path[d][m_pos-2]) begin
        m_pos--;
      end else begin
        m_err = 1;
        m_dir = 0;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // Drives one beam pattern for one clock. The model sees the same sampled
  // value, and the DUT outputs are tallied 1 time unit after the edge.
  task automatic step(input logic [1:0] ab);
    A = ab[1];
    B = ab[0];
    @(posedge CLK);
    if (RST) model_reset(); else model_step(ab);
    #1;
    n_enter += int'(enter);
    n_exit  += int'(exit);
    n_err   += int'(err);
  endtask

  task automatic clear_tallies();
    n_enter = 0; n_exit = 0; n_err = 0;
  endtask

  task automatic do_reset();
    A = 0; B = 0;
    RST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    clear_tallies();
  endtask

  task automatic drive_entry();
    step(2'b10); step(2'b11); step(2'b01); step(2'b00);
  endtask

  task automatic drive_exit();
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    model_reset();
    #3;
    checks++; if (count !== '0)   begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full  !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if ({enter, exit, err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {enter, exit, err});
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    clear_tallies();
  endtask

  task automatic test_entry();
    logic [1:0] seq [5];
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01; seq[4] = 2'b00;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(seq[i]);
      if (i < 4) step(seq[i]);
    end
    checks++; if (enter !== 1'b1) begin errors++; $display("FAIL entry_latency enter got %b want 1", enter); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL entry_count got %0d want 1", count); end
    step(2'b00);
    checks++; if (n_enter !== 1) begin errors++; $display("FAIL entry_pulses got %0d want 1", n_enter); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL entry_empty got %b want 0", empty); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL entry_err got %0d want 0", n_err); end
  endtask

  task automatic test_exit();
    clear_tallies();
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    checks++; if (exit !== 1'b1) begin errors++; $display("FAIL exit_latency exit got %b want 1", exit); end
    step(2'b00);
    checks++; if (n_exit !== 1) begin errors++; $display("FAIL exit_pulses got %0d want 1", n_exit); end
    checks++; if (count !== '0) begin errors++; $display("FAIL exit_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL exit_empty got %b want 1", empty); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL exit_err got %0d want 0", n_err); end
  endtask

  task automatic test_backout();
    do_reset();
    drive_entry();
    clear_tallies();
    step(2'b10); step(2'b11); step(2'b10); step(2'b00);
    step(2'b10); step(2'b00); step(2'b00);
    checks++; if (n_enter !== 0) begin errors++; $display("FAIL backout_enter got %0d want 0", n_enter); end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL backout_err got %0d want 0", n_err); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL backout_count got %0d want 1", count); end
  endtask

  task automatic test_illegal();
    clear_tallies();
    step(2'b10); step(2'b01);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_jump err got %b want 1", err); end
    step(2'b00);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_jump_width err got %b want 0", err); end
    step(2'b11);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_idle11 err got %b want 1", err); end
    step(2'b00);
    // a clean entry afterwards proves the FSM went back to IDLE
    drive_entry();
    checks++; if (enter !== 1'b1) begin errors++; $display("FAIL illegal_recover enter got %b want 1", enter); end
    checks++; if (n_err !== 2) begin errors++; $display("FAIL illegal_err_count got %0d want 2", n_err); end
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL illegal_count got %0d want 2", count); end
  endtask

  task automatic test_capacity();
    do_reset();
    for (int i = 0; i < CAPACITY; i++) drive_entry();
    checks++; if (count !== CW'(CAPACITY)) begin errors++; $display("FAIL cap_count got %0d want %0d", count, CAPACITY); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL cap_full got %b want 1", full); end
    clear_tallies();
    drive_entry();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cap_over_err got %b want 1", err); end
    step(2'b00);
    checks++; if (n_enter !== 0) begin errors++; $display("FAIL cap_over_enter got %0d want 0", n_enter); end
    checks++; if (count !== CW'(CAPACITY)) begin errors++; $display("FAIL cap_over_count got %0d want %0d", count, CAPACITY); end
    do_reset();
    drive_exit();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL under_err got %b want 1", err); end
    step(2'b00);
    checks++; if (n_exit !== 0) begin errors++; $display("FAIL under_exit got %0d want 0", n_exit); end
    checks++; if (count !== '0) begin errors++; $display("FAIL under_count got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_entry();
    step(2'b10); step(2'b11); step(2'b01);   // car now on the inner beam only
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL async_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_empty got %b want 1", empty); end
    @(posedge CLK); #1;
    RST = 1'b0;
    clear_tallies();
    step(2'b00); step(2'b00);
    checks++; if (n_enter !== 0) begin errors++; $display("FAIL async_noenter got %0d want 0", n_enter); end
    // an err pulse must also be cleared immediately by reset
    step(2'b11);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err got %b want 0", err); end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] ab;
    logic [1:0] prev;
    do_reset();
    prev = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      // repeat the last pattern half of the time to form longer sequences
      if ($urandom_range(1, 0) == 0) ab = prev;
      else ab = 2'($urandom_range(3, 0));
      prev = ab;
      step(ab);
      checks++;
      if ({enter, exit, err} !== {m_enter, m_exit, m_err}) begin
        errors++;
        $display("FAIL rand_pulses cyc %0d got %b want %b", i, {enter, exit, err}, {m_enter, m_exit, m_err});
      end
      checks++;
      if (count !== CW'(m_occ) || full !== (m_occ == CAPACITY) || empty !== (m_occ == 0)) begin
        errors++;
        $display("FAIL rand_count cyc %0d got %0d/%b/%b want %0d", i, count, full, empty, m_occ);
      end
      checks++;
      if (enter && exit) begin
        errors++;
        $display("FAIL rand_both cyc %0d got enter=1 exit=1 want not both", i);
      end
    end
  endtask

  initial begin
    model_reset();
    clear_tallies();
    test_reset();
    test_entry();
    test_exit();
    test_backout();
    test_illegal();
    test_capacity();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
